// File: rtl/cpu_defs_pkg.sv
// Shared CPU type definitions: BHT update payloads and the 2-bit counter transition.
package cpu_defs;

  localparam int unsigned VIRT_W = 32;

  typedef logic [VIRT_W-1:0] virt_t;

  typedef struct packed {
    logic       valid;
    virt_t      pc;
    logic [1:0] counter;
    logic       taken;
  } bht_update_t;

  // Queue storage form of an update; validity is implied by occupancy.
  typedef struct packed {
    virt_t      pc;
    logic [1:0] counter;
    logic       taken;
  } bht_entry_t;

  // Taken walks 00->01->11 (10->11); not-taken walks 11->10->00 (01->00).
  function automatic logic [1:0] bht_next_counter(input logic [1:0] counter, input logic taken);
    logic [1:0] nxt;
    nxt = counter;
    if (taken) begin
      case (counter)
        2'b00:   nxt = 2'b01;
        default: nxt = 2'b11;
      endcase
    end else begin
      case (counter)
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_update_queue.sv
// Dual-in / single-out FIFO feeding resolved branch outcomes to the BHT write port.
// Optional build macro BHT_UPDATE_MERGE_EN merges same-cycle updates to the same counter.
module bht_update_queue
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BHT_SIZE = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  bht_update_t [1:0] resolve,
  output logic              resolve_ready,
  output bht_update_t       update
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDX_HI = $clog2(BHT_SIZE / 2) + 2;

  bht_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [PTR_W-1:0]       tail_p1;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_nxt;
  logic [1:0]             push_cnt;
  logic                   pop;
  logic                   merge_hit;
  bht_entry_t             wr0;
  bht_entry_t             wr1;

  assign resolve_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign pop           = (count != '0);
  assign tail_p1       = tail + PTR_W'(1);

`ifdef BHT_UPDATE_MERGE_EN
  assign merge_hit = (resolve[0].pc[IDX_HI:2] == resolve[1].pc[IDX_HI:2]);
`else
  assign merge_hit = 1'b0;
`endif

  // Select what to enqueue this cycle, slot 0 ahead of slot 1.
  always_comb begin
    push_cnt = 2'd0;
    wr0      = '0;
    wr1      = '0;
    if (resolve_ready) begin
      if (resolve[0].valid && resolve[1].valid) begin
        if (merge_hit) begin
          wr0.pc      = resolve[1].pc;
          wr0.counter = bht_next_counter(resolve[0].counter, resolve[0].taken);
          wr0.taken   = resolve[1].taken;
          push_cnt    = 2'd1;
        end else begin
          wr0      = '{pc: resolve[0].pc, counter: resolve[0].counter, taken: resolve[0].taken};
          wr1      = '{pc: resolve[1].pc, counter: resolve[1].counter, taken: resolve[1].taken};
          push_cnt = 2'd2;
        end
      end else if (resolve[0].valid) begin
        wr0      = '{pc: resolve[0].pc, counter: resolve[0].counter, taken: resolve[0].taken};
        push_cnt = 2'd1;
      end else if (resolve[1].valid) begin
        wr0      = '{pc: resolve[1].pc, counter: resolve[1].counter, taken: resolve[1].taken};
        push_cnt = 2'd1;
      end
    end
    count_nxt = count + CNT_W'(push_cnt) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(push_cnt);
      count <= count_nxt;
      if (pop) head <= head + PTR_W'(1);
    end
  end

  // Payload storage needs no reset; occupancy gates the output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_cnt != 2'd0) mem[tail]    <= wr0;
      if (push_cnt == 2'd2) mem[tail_p1] <= wr1;
    end
  end

  always_comb begin
    update = '0;
    if (pop) begin
      update.valid   = 1'b1;
      update.pc      = mem[head].pc;
      update.counter = mem[head].counter;
      update.taken   = mem[head].taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_nxt <= CNT_W'(DEPTH));
      assert (DEPTH >= 4 && (DEPTH & (DEPTH - 1)) == 0 && BHT_SIZE >= 8);
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue: expected updates are queued as resolutions are accepted.
module tb_bht_update_queue;
  import cpu_defs::*;

  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  bht_update_t [1:0] resolve = '0;
  logic              resolve_ready;
  bht_update_t       update;

  bht_update_t       sb [$];
  int                n_checks = 0;
  int                n_errors = 0;

  bht_update_queue #(.DEPTH(DEPTH), .BHT_SIZE(4096)) dut (
    .clk           (clk),
    .rst           (rst),
    .resolve       (resolve),
    .resolve_ready (resolve_ready),
    .update        (update)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_next(input logic [1:0] c, input logic t);
    logic [1:0] r;
    case ({t, c})
      3'b100: r = 2'b01;
      3'b101: r = 2'b11;
      3'b110: r = 2'b11;
      3'b111: r = 2'b11;
      3'b011: r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic bht_update_t mk(input logic v, input logic [31:0] pc, input logic [1:0] c, input logic t);
    bht_update_t u;
    u.valid = v; u.pc = pc; u.counter = c; u.taken = t;
    return u;
  endfunction

  function automatic bit same_idx(input logic [31:0] a, input logic [31:0] b);
    return a[13:2] == b[13:2];
  endfunction

  // Check the current output, then model the coming edge and drive the next resolve pair.
  task automatic cycle(input bht_update_t s0, input bht_update_t s1);
    bit rdy;
    bit merge;
    @(negedge clk);
    if (sb.size() != 0) check("update", 64'(update), 64'(sb[0]));
    else                check("update_empty", 64'(update), 64'(0));
    rdy = (DEPTH - sb.size()) >= 2;
    check("resolve_ready", 64'(resolve_ready), 64'(rdy));
    if (sb.size() != 0) void'(sb.pop_front());
    merge = 1'b0;
`ifdef BHT_UPDATE_MERGE_EN
    merge = same_idx(s0.pc, s1.pc);
`endif
    if (rdy) begin
      if (s0.valid && s1.valid && merge) begin
        sb.push_back(mk(1'b1, s1.pc, ref_next(s0.counter, s0.taken), s1.taken));
      end else begin
        if (s0.valid) sb.push_back(s0);
        if (s1.valid) sb.push_back(s1);
      end
    end
    resolve[0] = s0;
    resolve[1] = s1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    resolve = '0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0);
  endtask

  initial begin
    bht_update_t a, b;
    do_reset();

    // Single push, one-cycle latency, then empty again.
    cycle(mk(1'b1, 32'h8000_0010, 2'b01, 1'b1), '0);
    idle(3);

    // Dual pushes every cycle: ready falls at count 7, pointers wrap.
    for (int k = 0; k < 10; k++) begin
      a = mk(1'b1, 32'h8000_1000 + 32'(k * 16), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      b = mk(1'b1, 32'h8000_1008 + 32'(k * 16), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cycle(a, b);
    end
    idle(10);

    // Slot 1 alone.
    cycle('0, mk(1'b1, 32'h8000_0104, 2'b10, 1'b0));
    idle(3);

    // Same-counter pair: merged or two separate writes depending on build.
    cycle(mk(1'b1, 32'h8000_0200, 2'b01, 1'b1), mk(1'b1, 32'h8000_0200, 2'b01, 1'b0));
    idle(4);

    // Fill to count 5, then reset mid-operation.
    for (int k = 0; k < 4; k++)
      cycle(mk(1'b1, 32'h8000_3000 + 32'(k * 16), 2'b11, 1'b1),
            mk(1'b1, 32'h8000_3004 + 32'(k * 16), 2'b00, 1'b0));
    do_reset();
    idle(4);

    // Random mix of slot validity, including occasional same-index pairs.
    for (int k = 0; k < 80; k++) begin
      a = mk(1'($urandom_range(0, 1)), 32'h8000_0000 | 32'($urandom_range(0, 63) * 4),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      b = mk(1'($urandom_range(0, 1)), 32'h8000_0000 | 32'($urandom_range(0, 63) * 4),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cycle(a, b);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
